riscv_mem_stallctrl: RTL and testbench

- Memory-stage sequencer for the M stage. It runs the data-memory request/ack handshake for loads, stores and AMOs (read-modify-write).
- Drives the pipeline hold (`en`, 1 = hold) for all pipeline registers, including the memory→writeback register, and that register's flush.
- Times out hung accesses as a bus error.
- Sits between the M-stage control decode, the trap unit and the data-memory/UART bus.

---
 rtl/riscv_mem_stallctrl_if.sv | 34 +++
 rtl/riscv_mem_stallctrl.sv | 109 ++++++++++
 tb/tb_riscv_mem_stallctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_stallctrl_if.sv
// M-stage data-memory handshake bundle: stage decode, trap and ack in; request, hold and flush out.
// The controller takes the slave modport; the pipeline/memory side takes master.
interface riscv_mem_stallctrl_if #(
  parameter int CNTW = 8
);
  logic            i_riscv_msc_memr_m;
  logic            i_riscv_msc_memw_m;
  logic            i_riscv_msc_amo_m;
  logic            i_riscv_msc_trap_m;
  logic            i_riscv_msc_dack;
  logic            o_riscv_msc_dreq;
  logic            o_riscv_msc_dwe;
  logic            o_riscv_msc_amo_wphase;
  logic            o_riscv_msc_stall;
  logic            o_riscv_msc_flush_mw;
  logic            o_riscv_msc_buserr;
  logic [CNTW-1:0] o_riscv_msc_waitcnt;

  modport slave (
    input  i_riscv_msc_memr_m, i_riscv_msc_memw_m, i_riscv_msc_amo_m,
           i_riscv_msc_trap_m, i_riscv_msc_dack,
    output o_riscv_msc_dreq, o_riscv_msc_dwe, o_riscv_msc_amo_wphase,
           o_riscv_msc_stall, o_riscv_msc_flush_mw, o_riscv_msc_buserr,
           o_riscv_msc_waitcnt
  );

  modport master (
    output i_riscv_msc_memr_m, i_riscv_msc_memw_m, i_riscv_msc_amo_m,
           i_riscv_msc_trap_m, i_riscv_msc_dack,
    input  o_riscv_msc_dreq, o_riscv_msc_dwe, o_riscv_msc_amo_wphase,
           o_riscv_msc_stall, o_riscv_msc_flush_mw, o_riscv_msc_buserr,
           o_riscv_msc_waitcnt
  );
endinterface

// File: rtl/riscv_mem_stallctrl.sv
// M-stage memory sequencer: zero added latency on same-cycle ack, AMO min 2 cycles, hung beats time out.
// Holds the whole pipeline (stall) until ack; timeout or IDLE trap flushes the M->W register instead.
module riscv_mem_stallctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 8
) (
  input  logic                      i_riscv_msc_clk,
  input  logic                      i_riscv_msc_rst_n,
  riscv_mem_stallctrl_if.slave      bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] WR_WAIT = 3'd2;
  localparam logic [2:0] AMO_RD  = 3'd3;
  localparam logic [2:0] AMO_WR  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CNTW-1:0] waitcnt_q, waitcnt_d;
  logic            dreq_c, dwe_c, wphase_c, stall_c, flush_c, buserr_c;
  logic            dack, timeout;

  assign dack    = bus.i_riscv_msc_dack;
  assign timeout = (state_q != IDLE) && !dack && (waitcnt_q == CNTW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    dreq_c   = 1'b0;
    dwe_c    = 1'b0;
    wphase_c = 1'b0;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    buserr_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_riscv_msc_trap_m) begin
          flush_c = 1'b1;
        end else if (bus.i_riscv_msc_amo_m) begin
          dreq_c  = 1'b1;
          stall_c = 1'b1;
          state_d = dack ? AMO_WR : AMO_RD;
        end else if (bus.i_riscv_msc_memw_m) begin
          dreq_c  = 1'b1;
          dwe_c   = 1'b1;
          stall_c = !dack;
          state_d = dack ? IDLE : WR_WAIT;
        end else if (bus.i_riscv_msc_memr_m) begin
          dreq_c  = 1'b1;
          stall_c = !dack;
          state_d = dack ? IDLE : RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        dreq_c  = 1'b1;
        dwe_c   = (state_q == WR_WAIT);
        stall_c = !dack;
        if (dack) state_d = IDLE;
      end
      AMO_RD: begin
        dreq_c  = 1'b1;
        stall_c = 1'b1;
        if (dack) state_d = AMO_WR;
      end
      AMO_WR: begin
        dreq_c   = 1'b1;
        dwe_c    = 1'b1;
        wphase_c = 1'b1;
        stall_c  = !dack;
        if (dack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Timeout drops the hold and flushes so the faulting instruction never writes back.
    if (timeout) begin
      stall_c  = 1'b0;
      flush_c  = 1'b1;
      buserr_c = 1'b1;
      state_d  = IDLE;
    end
  end

  always_comb begin
    waitcnt_d = waitcnt_q;
    if (state_d != state_q)
      waitcnt_d = '0;
    else if ((state_q != IDLE) && !dack && (waitcnt_q != {CNTW{1'b1}}))
      waitcnt_d = waitcnt_q + 1'b1;
  end

  always_ff @(posedge i_riscv_msc_clk or negedge i_riscv_msc_rst_n) begin
    if (!i_riscv_msc_rst_n) begin
      state_q   <= IDLE;
      waitcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
    end
  end

  // Outputs are gated by reset so an in-flight beat is dropped the instant reset asserts.
  assign bus.o_riscv_msc_dreq       = i_riscv_msc_rst_n & dreq_c;
  assign bus.o_riscv_msc_dwe        = i_riscv_msc_rst_n & dwe_c;
  assign bus.o_riscv_msc_amo_wphase = i_riscv_msc_rst_n & wphase_c;
  assign bus.o_riscv_msc_stall      = i_riscv_msc_rst_n & stall_c;
  assign bus.o_riscv_msc_flush_mw   = i_riscv_msc_rst_n & flush_c;
  assign bus.o_riscv_msc_buserr     = i_riscv_msc_rst_n & buserr_c;
  assign bus.o_riscv_msc_waitcnt    = waitcnt_q;

endmodule

// File: tb/tb_riscv_mem_stallctrl.sv
// Directed bench for riscv_mem_stallctrl (TIMEOUT=4): stimulus pushes expected outputs per active
// cycle, a negedge monitor pops and compares whenever dreq, flush_mw or buserr is presented.
module tb_riscv_mem_stallctrl;

  localparam int CNTW = 8;

  typedef struct {
    string       name;
    logic [13:0] v;   // {dreq, dwe, wphase, stall, flush, buserr, waitcnt[7:0]}
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  riscv_mem_stallctrl_if #(.CNTW(CNTW)) bus ();

  riscv_mem_stallctrl #(.TIMEOUT(4), .CNTW(CNTW)) dut (
    .i_riscv_msc_clk   (clk),
    .i_riscv_msc_rst_n (rst_n),
    .bus               (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] ev(input logic dreq, input logic dwe, input logic wph,
                                     input logic stall, input logic flush, input logic berr,
                                     input int cnt);
    return {dreq, dwe, wph, stall, flush, berr, 8'(cnt)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus.o_riscv_msc_dreq, bus.o_riscv_msc_dwe, bus.o_riscv_msc_amo_wphase,
            bus.o_riscv_msc_stall, bus.o_riscv_msc_flush_mw, bus.o_riscv_msc_buserr,
            bus.o_riscv_msc_waitcnt};
  endfunction

  task automatic drive(input logic r, input logic w, input logic a, input logic t, input logic k);
    bus.i_riscv_msc_memr_m = r;
    bus.i_riscv_msc_memw_m = w;
    bus.i_riscv_msc_amo_m  = a;
    bus.i_riscv_msc_trap_m = t;
    bus.i_riscv_msc_dack   = k;
  endtask

  // One cycle: inputs applied just after the rising edge; an expected vector is queued when the
  // bench expects the DUT to present activity in that cycle.
  task automatic step(input string name, input logic r, input logic w, input logic a,
                      input logic t, input logic k, input logic [13:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    drive(r, w, a, t, k);
    if (e[13] || e[9] || e[8]) begin
      x.name = name;
      x.v    = e;
      sb.push_back(x);
    end
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.o_riscv_msc_dreq || bus.o_riscv_msc_flush_mw || bus.o_riscv_msc_buserr)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_activity got %b want none", dut_vec());
        end else begin
          x = sb.pop_front();
          check(x.name, dut_vec(), x.v);
        end
      end
    end
  end

  initial begin : stimulus
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset_outputs", dut_vec(), 14'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle load, back to back.
    step("ld_fast0",   1, 0, 0, 0, 1, ev(1,0,0,0,0,0,0));
    step("ld_fast1",   1, 0, 0, 0, 1, ev(1,0,0,0,0,0,0));
    step("idle",       0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0));

    // Store acked in the fourth cycle.
    step("st_idle",    0, 1, 0, 0, 0, ev(1,1,0,1,0,0,0));
    step("st_w0",      0, 1, 0, 0, 0, ev(1,1,0,1,0,0,0));
    step("st_w1",      0, 1, 0, 0, 0, ev(1,1,0,1,0,0,1));
    step("st_ack",     0, 1, 0, 0, 1, ev(1,1,0,0,0,0,2));
    step("idle",       0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0));

    // AMO with immediate acks.
    step("amo_rd",     0, 0, 1, 0, 1, ev(1,0,0,1,0,0,0));
    step("amo_wr",     0, 0, 1, 0, 1, ev(1,1,1,0,0,0,0));
    step("idle",       0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0));

    // AMO with waits in both phases.
    step("amos_idle",  0, 0, 1, 0, 0, ev(1,0,0,1,0,0,0));
    step("amos_rd0",   0, 0, 1, 0, 0, ev(1,0,0,1,0,0,0));
    step("amos_rdack", 0, 0, 1, 0, 1, ev(1,0,0,1,0,0,1));
    step("amos_wr0",   0, 0, 1, 0, 0, ev(1,1,1,1,0,0,0));
    step("amos_wrack", 0, 0, 1, 0, 1, ev(1,1,1,0,0,0,1));
    step("idle",       0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0));

    // Load that never acks: bus error once waitcnt reaches TIMEOUT-1.
    step("to_idle",    1, 0, 0, 0, 0, ev(1,0,0,1,0,0,0));
    step("to_w0",      1, 0, 0, 0, 0, ev(1,0,0,1,0,0,0));
    step("to_w1",      1, 0, 0, 0, 0, ev(1,0,0,1,0,0,1));
    step("to_w2",      1, 0, 0, 0, 0, ev(1,0,0,1,0,0,2));
    step("to_berr",    1, 0, 0, 0, 0, ev(1,0,0,0,1,1,3));
    step("to_after",   1, 0, 0, 0, 1, ev(1,0,0,0,0,0,0));
    step("idle",       0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0));

    // Ack in the timeout cycle wins.
    step("tw_idle",    0, 1, 0, 0, 0, ev(1,1,0,1,0,0,0));
    step("tw_w0",      0, 1, 0, 0, 0, ev(1,1,0,1,0,0,0));
    step("tw_w1",      0, 1, 0, 0, 0, ev(1,1,0,1,0,0,1));
    step("tw_w2",      0, 1, 0, 0, 0, ev(1,1,0,1,0,0,2));
    step("tw_ack",     0, 1, 0, 0, 1, ev(1,1,0,0,0,0,3));
    step("idle",       0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0));

    // Trap in IDLE, then a trap raised during a wait state.
    step("trap_idle",  1, 0, 0, 1, 1, ev(0,0,0,0,1,0,0));
    step("tr_ld",      1, 0, 0, 0, 0, ev(1,0,0,1,0,0,0));
    step("tr_wait",    1, 0, 0, 1, 0, ev(1,0,0,1,0,0,0));
    step("tr_ack",     1, 0, 0, 1, 1, ev(1,0,0,0,0,0,1));
    step("tr_flush",   1, 0, 0, 1, 0, ev(0,0,0,0,1,0,0));
    step("idle",       0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0));

    // Priority amo > memw > memr.
    step("pri_amo",    1, 1, 1, 0, 1, ev(1,0,0,1,0,0,0));
    step("pri_amo_wr", 1, 1, 1, 0, 1, ev(1,1,1,0,0,0,0));
    step("pri_st",     1, 1, 0, 0, 1, ev(1,1,0,0,0,0,0));
    step("idle",       0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0));

    // Reset in AMO_RD after a couple of wait cycles.
    step("rs_idle",    0, 0, 1, 0, 0, ev(1,0,0,1,0,0,0));
    step("rs_rd0",     0, 0, 1, 0, 0, ev(1,0,0,1,0,0,0));
    step("rs_rd1",     0, 0, 1, 0, 0, ev(1,0,0,1,0,0,1));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_out", {bus.o_riscv_msc_dreq, bus.o_riscv_msc_stall, bus.o_riscv_msc_dwe},
          3'b000);
    check("rst_async_cnt", {6'd0, bus.o_riscv_msc_waitcnt}, 14'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release", dut_vec(), 14'd0);
    step("post_rst_ld", 1, 0, 0, 0, 1, ev(1,0,0,0,0,0,0));
    step("idle",        0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0));

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0 (next %s)", sb.size(), sb[0].name);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
